// File: rtl/apb_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_master_if : command/response and APB3 bus bundle for apb_master  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface apb_master_if #(
  parameter int ADDR_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_master : single-beat command to APB3 transfer initiator          |
// | Optional ACCESS timeout abort enabled by APB_MASTER_TIMEOUT_EN       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          pclk,
  input  logic          nreset,
  apb_master_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  generate
    if (TIMEOUT < 1) begin : g_timeout_check
      $error("apb_master: TIMEOUT must be at least 1");
    end
  endgenerate

  state_t            r_state;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [31:0]       r_pwdata;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
  logic [c_CNT_W-1:0]            r_wait_cnt;
`endif

  always_ff @(posedge pclk) begin
    if (!nreset) begin
      r_state     <= S_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      r_wait_cnt  <= '0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_state  <= S_SETUP;
            r_psel   <= 1'b1;
            r_pwrite <= bus.cmd_write;
            r_paddr  <= bus.cmd_addr;
            r_pwdata <= bus.cmd_wdata;
          end
        end
        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        S_ACCESS: begin
          if (bus.PREADY) begin
            r_state     <= S_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= bus.PSLVERR;
            r_rsp_rdata <= r_pwrite ? 32'd0 : bus.PRDATA;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          // Slave stalled for TIMEOUT access cycles: give up and report an error
          else if (r_wait_cnt == c_CNT_LAST) begin
            r_state     <= S_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= 32'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_apb_master : randomized scoreboard bench for apb_master           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_apb_master;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 4;

  typedef struct {
    int          hs;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          n;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    int          w;
    logic        err;
    logic [31:0] rdata;
  } slv_t;

  logic pclk = 1'b0;
  logic nreset = 1'b0;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  exp_t exp_q[$];
  slv_t slave_q[$];

  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  logic        last_wr = 1'b0;
  logic [7:0]  last_addr = '0;
  logic [31:0] last_wdata = '0;

  apb_master_if #(.ADDR_W(ADDR_W)) bus ();

  apb_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .pclk   (pclk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic summary();
    $display("%0d/%0d checks passed", n_pass, n_total);
  endtask

  // Reference: a transfer occupies one SETUP cycle plus n ACCESS cycles,
  // and its response appears the cycle after the last ACCESS cycle.
  task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                       input int w, input logic err, input logic [31:0] rd,
                       input bit hold, output int hs);
    exp_t e;
    slv_t s;
    bit   aborted;
    int   guard;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    guard = 0;
    while (!bus.cmd_ready && guard < 400) begin
      @(negedge pclk);
      guard++;
    end
    hs = cyc;
    if (!bus.cmd_ready) begin
      chk("cmd_ready_wait", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b0;
      return;
    end
`ifdef APB_MASTER_TIMEOUT_EN
    aborted = (w >= TIMEOUT);
`else
    aborted = 1'b0;
`endif
    e.hs = hs; e.wr = wr; e.addr = addr; e.wdata = wd;
    e.n     = aborted ? TIMEOUT : w + 1;
    e.err   = aborted ? 1'b1 : err;
    e.rdata = (wr || aborted) ? 32'd0 : rd;
    exp_q.push_back(e);
    s.w = w; s.err = err; s.rdata = rd;
    slave_q.push_back(s);
    @(negedge pclk);
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = 8'($urandom);
    bus.cmd_wdata = $urandom;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  // Slave model: stalls w ACCESS cycles, then completes; PRDATA/PSLVERR are noise otherwise.
  slv_t cur;
  int   acc = 0;
  always @(negedge pclk) begin
    if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b0) begin
      if (slave_q.size() != 0) cur = slave_q.pop_front();
      acc = 0;
    end
    if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
      if (acc < cur.w) begin
        bus.PREADY  = 1'b0;
        bus.PRDATA  = $urandom;
        bus.PSLVERR = 1'($urandom);
        acc++;
      end else begin
        bus.PREADY  = 1'b1;
        bus.PRDATA  = cur.rdata;
        bus.PSLVERR = cur.err;
      end
    end else begin
      bus.PREADY  = 1'($urandom);
      bus.PRDATA  = $urandom;
      bus.PSLVERR = 1'($urandom);
    end
  end

  // Monitor: compares every cycle against the front of the expectation queue.
  always @(negedge pclk) begin : mon
    exp_t e;
    int   c;
    if (mon_en) begin
      if (exp_q.size() != 0 && (cyc - exp_q[0].hs) == exp_q[0].n + 2) begin
        e = exp_q.pop_front();
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_err", bus.rsp_err, e.err);
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("psel_at_rsp", bus.PSEL, 0);
        chk("penable_at_rsp", bus.PENABLE, 0);
        chk("cmd_ready_at_rsp", bus.cmd_ready, 1);
        last_rdata = e.rdata; last_err = e.err;
        last_wr = e.wr; last_addr = e.addr; last_wdata = e.wdata;
      end else if (exp_q.size() == 0 || cyc == exp_q[0].hs) begin
        chk("idle_psel", bus.PSEL, 0);
        chk("idle_penable", bus.PENABLE, 0);
        chk("idle_cmd_ready", bus.cmd_ready, 1);
        chk("idle_rsp_valid", bus.rsp_valid, 0);
        chk("hold_rsp_rdata", bus.rsp_rdata, last_rdata);
        chk("hold_rsp_err", bus.rsp_err, last_err);
        chk("hold_paddr", bus.PADDR, last_addr);
        chk("hold_pwrite", bus.PWRITE, last_wr);
        chk("hold_pwdata", bus.PWDATA, last_wdata);
      end else begin
        e = exp_q[0];
        c = cyc - e.hs;
        chk("xfer_psel", bus.PSEL, 1);
        chk("xfer_penable", bus.PENABLE, (c >= 2) ? 1 : 0);
        chk("xfer_cmd_ready", bus.cmd_ready, 0);
        chk("xfer_rsp_valid", bus.rsp_valid, 0);
        chk("xfer_paddr", bus.PADDR, e.addr);
        chk("xfer_pwrite", bus.PWRITE, e.wr);
        chk("xfer_pwdata", bus.PWDATA, e.wdata);
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_psel"}, bus.PSEL, 0);
    chk({tag, "_penable"}, bus.PENABLE, 0);
    chk({tag, "_pwrite"}, bus.PWRITE, 0);
    chk({tag, "_paddr"}, bus.PADDR, 0);
    chk({tag, "_pwdata"}, bus.PWDATA, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "_rsp_err"}, bus.rsp_err, 0);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
  endtask

  initial begin : watchdog
    #200000;
    n_total++;
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    summary();
    $finish;
  end

  initial begin : driver
    int hs;
    int h[4];
    int g;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    nreset = 1'b0;
    repeat (3) @(negedge pclk);
    nreset = 1'b1;
    reset_checks("reset");
    mon_en = 1'b1;

    issue(1'b1, 8'h08, 32'h0000_0001, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, hs);
    repeat (4) @(negedge pclk);
    issue(1'b0, 8'h04, 32'h0, 3, 1'b0, 32'h1234_5678, 1'b0, hs);
    repeat (8) @(negedge pclk);
    issue(1'b0, 8'h0C, 32'h0, 0, 1'b1, 32'hCAFE_0001, 1'b0, hs);
    issue(1'b0, 8'h10, 32'h0, 0, 1'b0, 32'hA5A5_5A5A, 1'b0, hs);
    repeat (4) @(negedge pclk);

    for (int k = 0; k < 4; k++)
      issue(1'(k % 2), 8'(8'h20 + k), $urandom, 0, 1'b0, $urandom, (k < 3), h[k]);
    for (int k = 1; k < 4; k++) chk("b2b_spacing", h[k] - h[k-1], 3);
    repeat (4) @(negedge pclk);

    // Timeout boundary: last permitted stall, then one stall too many
    issue(1'b0, 8'h30, 32'h0, TIMEOUT - 1, 1'b0, 32'h0BAD_F00D, 1'b0, hs);
    issue(1'b0, 8'h34, 32'h0, TIMEOUT, 1'b0, 32'h1357_9BDF, 1'b0, hs);
    issue(1'b1, 8'h38, $urandom, 120, 1'b0, 32'h0, 1'b0, hs);
    repeat (4) @(negedge pclk);

    issue(1'b0, 8'h44, 32'h0, 20, 1'b0, 32'h7777_7777, 1'b0, hs);
    repeat (4) @(negedge pclk);
    nreset = 1'b0;
    mon_en = 1'b0;
    exp_q.delete();
    slave_q.delete();
    @(negedge pclk);
    nreset = 1'b1;
    reset_checks("midreset");
    last_rdata = '0; last_err = 1'b0; last_wr = 1'b0; last_addr = '0; last_wdata = '0;
    mon_en = 1'b1;
    repeat (2) @(negedge pclk);

    for (int i = 0; i < 150; i++) begin
      bit hold;
      hold = 1'($urandom);
      issue(1'($urandom), 8'($urandom), $urandom, int'($urandom_range(0, 6)),
            ($urandom_range(0, 3) == 0), $urandom, hold, hs);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge pclk);
    end
    bus.cmd_valid = 1'b0;

    g = 0;
    while (exp_q.size() != 0 && g < 1000) begin
      @(negedge pclk);
      g++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) @(negedge pclk);
    summary();
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/apb_master.md
# apb_master

APB initiator for the peripheral subsystem. It turns single-beat commands from a local requester, such as the processor-side bus bridge or the test sequencer, into APB3 transfers toward peripheral slaves like the delay timer. It runs the SETUP/ACCESS phase sequence, inserts wait states on PREADY, and returns read data plus error status on a one-cycle response strobe.

## Interface
- ADDR_W, 8, APB address width
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort (≥1); used only with the timeout macro
- pclk  in  1  clock; all logic on rising edge
- nreset  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  read data; 0 for writes and aborts
- rsp_err  out  1  PSLVERR sampled, or timeout abort
- PSEL  out  1  slave select
- PENABLE  out  1  access phase
- PWRITE  out  1  direction
- PADDR  out  ADDR_W  address
- PWDATA  out  32  write data
- PRDATA  in  32  read data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error

## Operation
- FSM states and outputs:
  - IDLE: PSEL=0, PENABLE=0, cmd_ready=1.
  - SETUP: PSEL=1, PENABLE=0, cmd_ready=0.
  - ACCESS: PSEL=1, PENABLE=1, cmd_ready=0.
- Transitions:
  - IDLE → SETUP on handshake. cmd_write, cmd_addr and cmd_wdata are registered into PWRITE, PADDR and PWDATA on that edge.
  - SETUP → ACCESS unconditionally.
  - ACCESS → IDLE when PREADY=1. Otherwise stay in ACCESS, or abort on timeout.
- Completion (PREADY=1 in ACCESS):
  - next cycle rsp_valid=1 and rsp_err=PSLVERR
  - rsp_rdata=PRDATA for reads, 0 for writes
- The response has no backpressure. rsp_rdata and rsp_err hold until the next response. rsp_valid is high for exactly one cycle.
- PWRITE, PADDR and PWDATA stay stable from SETUP through the end of ACCESS, then hold their last values in IDLE.
- PSLVERR and PRDATA are ignored unless PENABLE && PREADY.
- Reset at any time, including mid-transfer: every register returns to its reset value at the next edge. No response is issued for the interrupted transfer.
- Reset values:
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0
  - rsp_valid=0, rsp_rdata=0, rsp_err=0
  - cmd_ready=1 (state IDLE)

## Timing
- Zero-wait transfer:
  - cycle 0: handshake
  - cycle 1: SETUP
  - cycle 2: ACCESS with PREADY=1
  - cycle 3: rsp_valid=1, cmd_ready=1
- A new handshake is allowed in cycle 3. Back-to-back throughput is one transfer per 3 cycles.
- Each cycle of PREADY=0 in ACCESS adds one cycle of latency.
- cmd_ready is a decode of state (combinational). It never depends on cmd_valid.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A counter of $clog2(TIMEOUT+1) bits is cleared on SETUP→ACCESS and increments on each ACCESS cycle with PREADY=0.
  - If PREADY=0 while count==TIMEOUT-1, the transfer aborts: state goes to IDLE, PSEL and PENABLE drop next cycle, rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - If PREADY=1 in that same cycle, the transfer completes normally.
- Not defined: no counter; ACCESS waits indefinitely for PREADY.

## Test plan
- Write, zero-wait: cmd write addr 0x08, data 0x00000001, slave PREADY=1.
  - Required: PSEL rises cycle 1, PENABLE cycle 2, PWRITE=1, PADDR=0x08, PWDATA=0x00000001.
  - Required: rsp_valid cycle 3 with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: cmd read addr 0x04; PREADY low for 3 ACCESS cycles, then high with PRDATA=0x12345678.
  - Required: rsp_valid 6 cycles after handshake, rsp_rdata=0x12345678.
  - Required: PADDR is stable throughout.
- Slave error: read addr 0x0C with PREADY=1, PSLVERR=1.
  - Required: rsp_err=1 on the strobe.
  - Required: the next command completes with rsp_err=0.
- Back-to-back: cmd_valid held high with 4 commands queued.
  - Required: handshakes at cycles 0, 3, 6, 9; no cycle with PENABLE=1 && PSEL=0.
- Timeout (macro on, TIMEOUT=4): PREADY held low.
  - Required: 4 ACCESS cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0, and PSEL=0 in the same cycle.
  - Macro off: PSEL stays high for 100 cycles with no rsp_valid.
- Reset mid-ACCESS: nreset=0 for one cycle during wait states.
  - Required: next cycle all outputs at reset values, cmd_ready=1, no rsp_valid.
